// File: rtl/led_drv_pkg.sv
// Shared constants and types for the LED PWM driver.
// The PWM frame is 15 steps long, so a 4-bit brightness of 15 is always on.
package led_drv_pkg;

   localparam int PWM_STEPS = 15;
   localparam int PWM_W     = 4;
   localparam int LED_W     = 8;

   typedef logic [PWM_W-1:0] pwm_t;
   typedef logic [LED_W-1:0] led_t;

   localparam pwm_t PWM_LAST = PWM_W'(PWM_STEPS - 1);

endpackage

// File: rtl/led_prescaler.sv
// Free-running divider: step_tick is high for one cycle out of every PRESCALE.
// With PRESCALE = 1 the counter never leaves zero and step_tick is always high.
module led_prescaler #(
   parameter int PRESCALE = 256
) (
   input  logic clk,
   input  logic reset_n,
   output logic step_tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] count;

   assign step_tick = (count == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (step_tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/led_pwm_driver.sv
// Eight-channel LED driver: global 15-step PWM brightness plus optional blink,
// with the request inputs sampled once per frame so a frame is never torn.
module led_pwm_driver
   import led_drv_pkg::*;
#(
   parameter int PRESCALE     = 256,
   parameter int BLINK_FRAMES = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [LED_W-1:0] led_pattern,
   input  logic [PWM_W-1:0] brightness,
   input  logic             blink_en,
   output logic [LED_W-1:0] led_out,
   output logic             frame_tick
);

   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic          step_tick;
   logic          frame_start;
   logic          lit;
   pwm_t          pwm_cnt;
   pwm_t          shadow_brightness;
   led_t          shadow_pattern;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   led_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk       (clk),
      .reset_n   (reset_n),
      .step_tick (step_tick)
   );

   assign frame_start = step_tick && (pwm_cnt == PWM_LAST);
   assign lit         = (pwm_cnt < shadow_brightness) && blink_phase;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt <= '0;
      end else if (step_tick) begin
         pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_W'(1);
      end
   end

   // Shadows only move at the frame boundary; mid-frame input edits wait.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_pattern    <= '0;
         shadow_brightness <= '0;
      end else if (frame_start) begin
         shadow_pattern    <= led_pattern;
         shadow_brightness <= brightness;
      end
   end

   // Holding the counter at zero while disabled makes a fresh enable start
   // in the on phase with a full BLINK_FRAMES before the first toggle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (!blink_en) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (frame_start) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_out    <= '0;
         frame_tick <= 1'b0;
      end else begin
         led_out    <= shadow_pattern & {LED_W{lit}};
         frame_tick <= frame_start;
      end
   end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver: PRESCALE = 2 main instance (30-cycle
// frames) plus a PRESCALE = 1 instance for the 15-cycle frame period.
module tb_led_pwm_driver;

   localparam int FRAME = 30;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] led_pattern = 8'h00;
   logic [3:0] brightness = 4'd0;
   logic       blink_en = 1'b0;
   logic [7:0] led_out;
   logic       frame_tick;
   logic [7:0] led_out_p1;
   logic       frame_tick_p1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_pwm_driver #(.PRESCALE(2), .BLINK_FRAMES(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .led_pattern (led_pattern),
      .brightness  (brightness),
      .blink_en    (blink_en),
      .led_out     (led_out),
      .frame_tick  (frame_tick)
   );

   led_pwm_driver #(.PRESCALE(1), .BLINK_FRAMES(2)) dut_p1 (
      .clk         (clk),
      .reset_n     (reset_n),
      .led_pattern (led_pattern),
      .brightness  (brightness),
      .blink_en    (blink_en),
      .led_out     (led_out_p1),
      .frame_tick  (frame_tick_p1)
   );

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Call at the negedge where frame_tick is high; checks the next 30 samples.
   // The first on_cycles samples carry pat, the rest are dark.
   task automatic check_frame(input string tag, input logic [7:0] pat, input int on_cycles);
      for (int i = 1; i <= FRAME; i++) begin
         @(negedge clk);
         check($sformatf("%s led[%0d]", tag, i), 16'(led_out), 16'((i <= on_cycles) ? pat : 8'h00));
      end
      check({tag, " frame_tick"}, 16'(frame_tick), 16'd1);
   endtask

   // Call at a negedge just after reset release: dark for a whole frame,
   // with the first frame_tick landing exactly 30 cycles later.
   task automatic check_after_release(input string tag);
      for (int i = 1; i <= FRAME; i++) begin
         @(negedge clk);
         check($sformatf("%s led[%0d]", tag, i), 16'(led_out), 16'h00);
         check($sformatf("%s tick[%0d]", tag, i), 16'(frame_tick), 16'((i == FRAME) ? 1 : 0));
      end
   endtask

   task automatic wait_frame_tick(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 4 * FRAME);
      check({tag, " tick seen"}, 16'(frame_tick), 16'd1);
   endtask

   initial begin
      int gap;

      // Reset idle
      led_pattern = 8'hFF;
      brightness  = 4'd15;
      repeat (3) @(negedge clk);
      check("reset led_out", 16'(led_out), 16'h00);
      check("reset frame_tick", 16'(frame_tick), 16'd0);
      reset_n = 1'b1;
      check_after_release("idle");
      check_frame("idle full", 8'hFF, 30);

      // Duty 5/15
      led_pattern = 8'hA5;
      brightness  = 4'd5;
      check_frame("duty prev", 8'hFF, 30);
      check_frame("duty a", 8'hA5, 10);

      // Mid-frame change: 0x0F frame, edit to 0xF0 at cycle 7
      led_pattern = 8'h0F;
      brightness  = 4'd15;
      check_frame("duty b", 8'hA5, 10);
      for (int i = 1; i <= FRAME; i++) begin
         @(negedge clk);
         check($sformatf("mid 0F led[%0d]", i), 16'(led_out), 16'h0F);
         if (i == 7) led_pattern = 8'hF0;
      end
      check("mid boundary tick", 16'(frame_tick), 16'd1);
      check_frame("mid F0", 8'hF0, 30);

      // Brightness 0
      led_pattern = 8'hFF;
      brightness  = 4'd0;
      check_frame("br0 prev", 8'hF0, 30);
      check_frame("br0", 8'hFF, 0);

      // Blink: 2 frames on, 2 off
      led_pattern = 8'h01;
      brightness  = 4'd15;
      check_frame("blink prep", 8'hFF, 0);
      blink_en = 1'b1;
      check_frame("blink on1", 8'h01, 30);
      check_frame("blink on2", 8'h01, 30);
      check_frame("blink off1", 8'h01, 0);
      check_frame("blink off2", 8'h01, 0);
      check_frame("blink on3", 8'h01, 30);
      check_frame("blink on4", 8'h01, 30);
      repeat (5) @(negedge clk);
      check("blink off3", 16'(led_out), 16'h00);
      blink_en = 1'b0;
      repeat (2) @(negedge clk);
      check("blink drop", 16'(led_out), 16'h01);

      // Reset mid-frame at PWM step 9
      wait_frame_tick("rst sync");
      repeat (18) @(negedge clk);
      check("pre-rst led", 16'(led_out), 16'h01);
      reset_n = 1'b0;
      #1;
      check("async rst led", 16'(led_out), 16'h00);
      check("async rst tick", 16'(frame_tick), 16'd0);
      @(negedge clk);
      check("rst held led", 16'(led_out), 16'h00);
      reset_n = 1'b1;
      check_after_release("post-rst");
      check_frame("post-rst frame", 8'h01, 30);

      // PRESCALE = 1: 15-cycle frame period
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (!frame_tick_p1 && gap < 64);
      check("p1 tick seen", 16'(frame_tick_p1), 16'd1);
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (!frame_tick_p1 && gap < 64);
      check("p1 period", 16'(gap), 16'd15);
      check("p1 led", 16'(led_out_p1), 16'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
